// File: rtl/sensor_frame_assembler.sv
// Serial-to-parallel frame assembler feeding the MLP input vector. Gathers one frame while the
// previous one waits in the output register, and resynchronises on framing errors.
module sensor_frame_assembler #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data [N_CH],
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CH - 1);

    typedef enum logic [1:0] {StCollect, StPending, StResync} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DW-1:0]     buf_q [N_CH];
    logic [DW-1:0]     buf_d [N_CH];
    logic [DW-1:0]     m_data_q [N_CH];
    logic [DW-1:0]     m_data_d [N_CH];
    logic              m_valid_q, m_valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic handoff;
    logic slot_free;

    assign s_ready   = (state_q != StPending);
    assign accept    = s_valid && s_ready;
    assign handoff   = m_valid_q && m_ready;
    assign slot_free = !m_valid_q || m_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        err_d     = 1'b0;
        cnt_d     = handoff ? cnt_q + CNT_W'(1) : cnt_q;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (idx_q != LastIdx) begin
                        if (s_last) begin
                            // Short frame: drop what was gathered so far.
                            idx_d = '0;
                            err_d = 1'b1;
                        end else begin
                            buf_d[idx_q] = s_data;
                            idx_d        = idx_q + IdxW'(1);
                        end
                    end else if (s_last) begin
                        if (slot_free) begin
                            m_data_d           = buf_q;
                            m_data_d[N_CH-1]   = s_data;
                            m_valid_d          = 1'b1;
                            idx_d              = '0;
                        end else begin
                            buf_d[N_CH-1] = s_data;
                            state_d       = StPending;
                        end
                    end else begin
                        // Long frame: drop it and skip beats up to its s_last.
                        idx_d   = '0;
                        err_d   = 1'b1;
                        state_d = StResync;
                    end
                end
            end
            StPending: begin
                if (slot_free) begin
                    m_data_d  = buf_q;
                    m_valid_d = 1'b1;
                    idx_d     = '0;
                    state_d   = StCollect;
                end
            end
            StResync: begin
                if (accept && s_last) begin
                    idx_d   = '0;
                    state_d = StCollect;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCollect;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                buf_q[i]    <= '0;
                m_data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Bench for sensor_frame_assembler: directed framing scenarios plus a randomized run
// checked against a frame-level reference model.
module tb_sensor_frame_assembler;

    localparam int unsigned N_CH  = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data [N_CH];
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    int errors;
    int checks;
    int exp_cnt;

    sensor_frame_assembler #(
        .N_CH (N_CH),
        .DW   (DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mdata_flat();
        logic [47:0] r;
        for (int i = 0; i < N_CH; i++) r[i*8 +: 8] = m_data[i];
        return r;
    endfunction

    function automatic logic [47:0] seq_frame(input logic [7:0] base);
        logic [47:0] r;
        for (int i = 0; i < N_CH; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Presents one beat for exactly one rising edge; returns #1 after that edge.
    task automatic send_beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) send_beat(base + 8'(i), (i == len - 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: m_valid=%b frame_err=%b frame_cnt=%0d s_ready=%b, required 0 0 0 1",
                     m_valid, frame_err, frame_cnt, s_ready);
        end
        checks++;
        if (mdata_flat() !== 48'd0) begin
            errors++;
            $display("FAIL reset_m_data: got %h required 0", mdata_flat());
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: frame_err=%b m_valid=%b, required 0 0", frame_err, m_valid);
        end
        exp_cnt = 0;
    endtask

    task automatic test_single_frame();
        m_ready = 1'b1;
        send_frame(8'h10, 6);
        checks++;
        if (m_valid !== 1'b1 || mdata_flat() !== seq_frame(8'h10)) begin
            errors++;
            $display("FAIL single_frame_data: m_valid=%b m_data=%h, required 1 %h",
                     m_valid, mdata_flat(), seq_frame(8'h10));
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (m_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL single_frame_handoff: m_valid=%b frame_cnt=%0d, required 0 %0d",
                     m_valid, frame_cnt, exp_cnt);
        end
        m_ready = 1'b0;
    endtask

    task automatic drain_one(input logic [47:0] exp_data, input string name);
        checks++;
        if (m_valid !== 1'b1 || mdata_flat() !== exp_data) begin
            errors++;
            $display("FAIL %s_data: m_valid=%b m_data=%h, required 1 %h", name, m_valid,
                     mdata_flat(), exp_data);
        end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (m_valid !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_drain: m_valid=%b frame_cnt=%0d, required 0 %0d", name, m_valid,
                     frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        send_frame(8'h20, 6);
        send_frame(8'h30, 6);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || mdata_flat() !== seq_frame(8'h20)) begin
            errors++;
            $display("FAIL b2b_pending: s_ready=%b m_valid=%b m_data=%h, required 0 1 %h",
                     s_ready, m_valid, mdata_flat(), seq_frame(8'h20));
        end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (m_valid !== 1'b1 || mdata_flat() !== seq_frame(8'h30) || frame_cnt !== 16'(exp_cnt)
            || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reload: m_valid=%b m_data=%h frame_cnt=%0d s_ready=%b, required 1 %h %0d 1",
                     m_valid, mdata_flat(), frame_cnt, s_ready, seq_frame(8'h30), exp_cnt);
        end
        drain_one(seq_frame(8'h30), "b2b_second");
    endtask

    task automatic test_short_frame();
        send_frame(8'h40, 3);
        checks++;
        if (frame_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_err: frame_err=%b m_valid=%b, required 1 0", frame_err, m_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_width: frame_err=%b required 0", frame_err);
        end
        send_frame(8'hA0, 6);
        drain_one(seq_frame(8'hA0), "short_recover");
    endtask

    task automatic test_long_frame();
        for (int i = 0; i < 6; i++) send_beat(8'h50 + 8'(i), 1'b0);
        checks++;
        if (frame_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_err: frame_err=%b m_valid=%b, required 1 0", frame_err, m_valid);
        end
        send_beat(8'h56, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_resync: frame_err=%b m_valid=%b s_ready=%b, required 0 0 1",
                     frame_err, m_valid, s_ready);
        end
        send_frame(8'h60, 6);
        drain_one(seq_frame(8'h60), "long_recover");
    endtask

    task automatic test_random();
        beat_t       beats[$];
        logic [47:0] exp_q[$];
        logic [47:0] fr;
        logic [47:0] pd;
        beat_t       bt;
        logic        pv, pr, psv, psr;
        int          len, bi, cyc, exp_err, err_seen;
        exp_err = 0; err_seen = 0; bi = 0; cyc = 0; fr = '0;
        for (int f = 0; f < 1000; f++) begin
            if (f == 999 || $urandom_range(9) != 0) len = 6;
            else begin
                len = $urandom_range(8, 1);
                if (len >= 6) len++;
            end
            for (int b = 0; b < len; b++) begin
                bt.d = 8'($urandom);
                bt.l = (b == len - 1);
                beats.push_back(bt);
                if (len == 6) fr[b*8 +: 8] = bt.d;
            end
            if (len == 6) exp_q.push_back(fr);
            else exp_err++;
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        pv = m_valid; pr = 1'b0; psv = 1'b0; psr = s_ready; pd = mdata_flat();
        while ((bi < beats.size() || exp_q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (frame_err === 1'b1) err_seen++;
            if (pv && pr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_frame: got %h, required no frame", pd);
                end else begin
                    if (pd !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rand_frame_data: got %h required %h", pd, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                exp_cnt++;
                checks++;
                if (frame_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL rand_frame_cnt: got %0d required %0d", frame_cnt, exp_cnt);
                end
            end else if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || mdata_flat() !== pd) begin
                    errors++;
                    $display("FAIL rand_stall_stable: m_valid=%b m_data=%h, required 1 %h",
                             m_valid, mdata_flat(), pd);
                end
            end
            if (psv && psr) bi++;
            if (bi < beats.size() && ((psv && !psr) || $urandom_range(3) != 0)) begin
                s_valid = 1'b1;
                s_data  = beats[bi].d;
                s_last  = beats[bi].l;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            m_ready = ($urandom_range(2) != 0);
            pv = m_valid; pr = m_ready; psv = s_valid; psr = s_ready; pd = mdata_flat();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++;
        if (cyc >= 60000) begin
            errors++;
            $display("FAIL rand_timeout: beats consumed %0d of %0d, frames left %0d",
                     bi, beats.size(), exp_q.size());
        end
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL rand_frame_err_count: got %0d required %0d", err_seen, exp_err);
        end
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b0;
        send_frame(8'h70, 6);
        for (int i = 0; i < 4; i++) send_beat(8'h80 + 8'(i), 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0 || s_ready !== 1'b1
            || mdata_flat() !== 48'd0) begin
            errors++;
            $display("FAIL midreset_async: m_valid=%b frame_err=%b frame_cnt=%0d s_ready=%b m_data=%h, required 0 0 0 1 0",
                     m_valid, frame_err, frame_cnt, s_ready, mdata_flat());
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        m_ready = 1'b1;
        send_frame(8'h90, 6);
        checks++;
        if (m_valid !== 1'b1 || mdata_flat() !== seq_frame(8'h90)) begin
            errors++;
            $display("FAIL midreset_frame: m_valid=%b m_data=%h, required 1 %h",
                     m_valid, mdata_flat(), seq_frame(8'h90));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_cnt: got %0d required 1", frame_cnt);
        end
    endtask

    initial begin
        errors = 0; checks = 0; exp_cnt = 0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0; rst = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
